// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
// Byte-addressed RV32 data memory behind a valid/ready request port. It
// executes LB/LH/LW/LBU/LHU loads and SB/SH/SW stores with byte-lane writes,
// load sign/zero extension and misalignment/illegal-funct3 faults. Every
// request passes through IDLE -> [WAIT x WAIT_CYCLES] -> ACCESS -> RESP, and
// RESP produces a single-cycle response pulse.
//
// Ports
//   sysCLK     in   clock, rising edge
//   sysRST     in   synchronous active-high reset
//   reqValid   in   request present
//   reqReady   out  request accepted this cycle when reqValid is also high
//   reqWrite   in   1 = store, 0 = load
//   reqFunct3  in   RV32 funct3 width/sign code
//   reqAddr    in   byte address [ADDR_W-1:0]
//   reqWData   in   right-aligned store data
//   rspValid   out  one-cycle response pulse
//   rspRData   out  extended load data (0 for stores and faults), held
//   rspFault   out  misaligned/illegal request, qualify with rspValid
// -----------------------------------------------------------------------------
module data_memory_ctrl #(
   parameter int ADDR_W      = 16,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              sysCLK,
   input  logic              sysRST,
   input  logic              reqValid,
   output logic              reqReady,
   input  logic              reqWrite,
   input  logic [2:0]        reqFunct3,
   input  logic [ADDR_W-1:0] reqAddr,
   input  logic [31:0]       reqWData,
   output logic              rspValid,
   output logic [31:0]       rspRData,
   output logic              rspFault
);

   localparam int         DEPTH     = 2 ** (ADDR_W - 2);
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                write_q, write_d;
   logic [2:0]          funct3_q, funct3_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;

   logic                ready_q;
   logic                rsp_valid_q;
   logic [31:0]         rdata_q;
   logic                fault_q;

   logic [31:0]         mem_q [DEPTH];

   logic [ADDR_W-3:0]   word_idx_s;
   logic [1:0]          lane_s;
   logic                fault_s;
   logic [31:0]         rd_word_s;
   logic [31:0]         load_data_s;
   logic [3:0]          byte_en_s;
   logic [31:0]         st_data_s;
   logic                mem_we_s;

   // Fault when an access is misaligned for its width or funct3 is not a
   // legal load/store code.
   function automatic logic access_fault(input logic wr, input logic [2:0] f3,
                                         input logic [1:0] lane);
      logic flt;
      case (f3)
         3'b000:  flt = 1'b0;
         3'b001:  flt = lane[0];
         3'b010:  flt = (lane != 2'b00);
         3'b100:  flt = wr;
         3'b101:  flt = wr | lane[0];
         default: flt = 1'b1;
      endcase
      return flt;
   endfunction

   // Select the addressed byte/half and extend it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [2:0] f3,
                                                input logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b010:  r = word;
         3'b100:  r = {24'd0, b};
         3'b101:  r = {16'd0, h};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Byte-lane enables for a store of the given width at the given lane.
   function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] lane);
      logic [3:0] m;
      case (f3)
         3'b000:  m = 4'b0001 << lane;
         3'b001:  m = lane[1] ? 4'b1100 : 4'b0011;
         3'b010:  m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Access-stage decode: address split, fault check, lane data and write enable.
   always_comb begin
      word_idx_s  = addr_q[ADDR_W-1:2];
      lane_s      = addr_q[1:0];
      fault_s     = access_fault(write_q, funct3_q, lane_s);
      rd_word_s   = mem_q[word_idx_s];
      load_data_s = load_extract(rd_word_s, funct3_q, lane_s);
      byte_en_s   = store_mask(funct3_q, lane_s);
      // Replicate the right-aligned store data so every enabled lane sees it.
      case (funct3_q)
         3'b000:  st_data_s = {4{wdata_q[7:0]}};
         3'b001:  st_data_s = {2{wdata_q[15:0]}};
         default: st_data_s = wdata_q;
      endcase
      // A reset landing on the ACCESS edge drops the store.
      if ((state_q == S_ACCESS) && write_q && !fault_s && !sysRST) begin
         mem_we_s = 1'b1;
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // Next-state and request-capture logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      write_d  = write_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (reqValid && ready_q) begin
               write_d  = reqWrite;
               funct3_d = reqFunct3;
               addr_d   = reqAddr;
               wdata_d  = reqWData;
               cnt_d    = WAIT_INIT;
               if (WAIT_CYCLES > 0) begin
                  state_d = S_WAIT;
               end else begin
                  state_d = S_ACCESS;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_ACCESS;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACCESS: state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Control state, captured request and registered response outputs.
   always_ff @(posedge sysCLK) begin
      if (sysRST) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         write_q     <= 1'b0;
         funct3_q    <= 3'd0;
         addr_q      <= '0;
         wdata_q     <= 32'd0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 32'd0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ready_q     <= (state_d == S_IDLE);
         rsp_valid_q <= (state_d == S_RESP);
         if (state_q == S_ACCESS) begin
            rdata_q <= (write_q || fault_s) ? 32'd0 : load_data_s;
            fault_q <= fault_s;
         end
      end
   end

   // Storage array: byte-lane writes, contents survive reset.
   always_ff @(posedge sysCLK) begin
      if (mem_we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en_s[i]) begin
               mem_q[word_idx_s][i*8 +: 8] <= st_data_s[i*8 +: 8];
            end
         end
      end
   end

   assign reqReady = ready_q;
   assign rspValid = rsp_valid_q;
   assign rspRData = rdata_q;
   assign rspFault = fault_q;

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Byte-addressed 32-bit RV32 data memory with a valid/ready request port and a one-cycle response pulse. It executes loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) with byte-lane writes, load sign/zero extension and misalignment faults. It has a configurable number of wait states. It is the successor of the plain single-port data RAM and sits between the datapath's ALU address/rs2 outputs and the write-back mux.

Parameters:
ADDR_W, 16, byte-address width; storage is 2**(ADDR_W-2) words of 32 bits.
WAIT_CYCLES, 0, extra access cycles inserted between acceptance and response (0..15).

Ports:
sysCLK  input  1  clock; all state changes on its rising edge.
sysRST  input  1  reset, synchronous, active-high.
reqValid  input  1  request present.
reqReady  output  1  block can accept a request this cycle.
reqWrite  input  1  1 = store, 0 = load.
reqFunct3  input  3  RV32 funct3 width/sign code.
reqAddr  input  ADDR_W  byte address.
reqWData  input  32  store data, right-aligned (rs2).
rspValid  output  1  one-cycle response pulse.
rspRData  output  32  aligned, extended load data; 0 for stores and faults.
rspFault  output  1  misaligned or illegal request; qualified by rspValid.

Behaviour:
- Reset (sysRST=1 at an edge):
  - State goes to IDLE; reqReady=0, rspValid=0, rspRData=0, rspFault=0.
  - reqReady rises in the first cycle after sysRST is sampled low.
  - Storage contents are not cleared.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: reqReady=1. On reqValid&reqReady the block captures reqWrite/reqFunct3/reqAddr/reqWData. It goes to WAIT with cnt=WAIT_CYCLES-1 if WAIT_CYCLES>0, else to ACCESS.
  - WAIT: cnt decrements each cycle; at cnt==0 it goes to ACCESS.
  - ACCESS: one cycle. The store is committed to the array at the edge leaving ACCESS; load data and rspFault are registered. Next state is RESP.
  - RESP: rspValid=1 for exactly one cycle. Next state is IDLE.
- reqReady=0 in WAIT/ACCESS/RESP. reqValid and all req inputs are ignored there.
- Latency: the acceptance edge is at cycle N; rspValid is high in cycle N+2+WAIT_CYCLES. Throughput is one request per WAIT_CYCLES+3 cycles. There is no response backpressure.
- Word index = addr[ADDR_W-1:2]; lane = addr[1:0].
- Loads:
  - 000 LB: byte at lane, sign-extended.
  - 001 LH: half at lane[1], sign-extended.
  - 010 LW: full word.
  - 100 LBU and 101 LHU: as LB/LH but zero-extended.
- Stores write only the addressed lanes; other bytes of the word are unchanged.
  - 000 SB: reqWData[7:0] to the lane.
  - 001 SH: reqWData[15:0] to the lane pair.
  - 010 SW: full word.
- Fault conditions (rspFault=1, rspRData=0, no array write):
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - load funct3 in {011,110,111};
  - store funct3 >= 011.
- Non-fault responses: rspFault=0. Stores return rspRData=0.
- rspRData and rspFault hold their value outside RESP. Consumers must qualify them with rspValid.
- Reset mid-operation: if sysRST is asserted in WAIT or ACCESS, the transaction is dropped, no write occurs and no response is issued. If asserted in RESP, rspValid is forced to 0 in the following cycle per the reset rule.
- Reads of never-written locations return X in simulation. The bench initialises memory via stores before reading.

Test Plan:
- WAIT_CYCLES=0: SW addr 0x0010 data 0xDEADBEEF, then LW 0x0010 -> rspValid exactly 2 cycles after each acceptance; load returns 0xDEADBEEF with rspFault=0.
- After the above: SB 0x0011 data 0x000000AA, then LW 0x0010 -> 0xDEADAAEF; LB 0x0011 -> 0xFFFFFFAA; LBU 0x0011 -> 0x000000AA; LHU 0x0012 -> 0x0000DEAD; LH 0x0012 -> 0xFFFFDEAD.
- Misaligned: LW 0x0012, SH 0x0013 data 0x1234, LH 0x0011 -> each gives rspFault=1 and rspRData=0; a following LW 0x0010 still returns 0xDEADAAEF (no write).
- WAIT_CYCLES=3: reqValid held high continuously with back-to-back requests -> reqReady low for 5 cycles after each acceptance; rspValid exactly 5 cycles after acceptance; reqReady=1 one cycle after rspValid.
- Reset: assert sysRST during WAIT of an SW 0x0020 data 0x11111111 (location previously holds 0x22222222) -> no rspValid; reqReady=0 while in reset and 1 the first cycle after; LW 0x0020 returns 0x22222222.
- Illegal funct3: load 011 and store 011 at 0x0000 -> rspFault=1, rspRData=0, memory unchanged.
